mdu: RTL and testbench

Multiply/divide unit for the execute stage. It runs in parallel with the ALU on the same forwarded operands `v1`/`v2`, and owns the architectural HI/LO registers. It executes `mult`/`multu`/`div`/`divu` as multi-cycle operations with a busy counter, applies `mthi`/`mtlo` immediately, and returns HI/LO combinationally for `mfhi`/`mflo`. Its `busy` output feeds the hazard unit, which stalls F/D while any MD instruction is in flight.

---
 rtl/mdu.sv | 98 +++++++++
 tb/tb_mdu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit: owns HI/LO, runs mult/div as fixed-latency busy periods,
// applies mthi/mtlo immediately and returns HI/LO combinationally for mfhi/mflo.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] v1,
  input  logic [31:0] v2,
  input  logic [3:0]  opt,
  input  logic        start,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] res,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [3:0]  cnt;
  logic [31:0] p_hi, p_lo;
  logic        accept;
  logic        div_zero;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, q_mag, r_mag, q_s, r_s, q_u, r_u, div_u;

  assign busy     = (cnt != 4'd0);
  assign accept   = start & ~cancel & ~busy;
  assign div_zero = (v2 == 32'd0);

  assign prod_s = $signed({{32{v1[31]}}, v1}) * $signed({{32{v2[31]}}, v2});
  assign prod_u = {32'd0, v1} * {32'd0, v2};

  // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow corner.
  assign abs_a = v1[31] ? (~v1 + 32'd1) : v1;
  assign abs_b = div_zero ? 32'd1 : (v2[31] ? (~v2 + 32'd1) : v2);
  assign q_mag = abs_a / abs_b;
  assign r_mag = abs_a % abs_b;
  assign q_s   = (v1[31] ^ v2[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = v1[31] ? (~r_mag + 32'd1) : r_mag;

  assign div_u = div_zero ? 32'd1 : v2;
  assign q_u   = v1 / div_u;
  assign r_u   = v1 % div_u;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 4'd0;
      hi   <= 32'd0;
      lo   <= 32'd0;
      p_hi <= 32'd0;
      p_lo <= 32'd0;
    end else if (busy) begin
      // An in-flight op always completes, even under cancel.
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi <= p_hi;
        lo <= p_lo;
      end
    end else if (accept) begin
      case (opt)
        4'd1: begin
          {p_hi, p_lo} <= prod_s;
          cnt          <= MULT_CNT;
        end
        4'd2: begin
          {p_hi, p_lo} <= prod_u;
          cnt          <= MULT_CNT;
        end
        4'd3: begin
          {p_hi, p_lo} <= div_zero ? {hi, lo} : {r_s, q_s};
          cnt          <= DIV_CNT;
        end
        4'd4: begin
          {p_hi, p_lo} <= div_zero ? {hi, lo} : {r_u, q_u};
          cnt          <= DIV_CNT;
        end
        4'd5:    hi <= v1;
        4'd6:    lo <= v1;
        default: ;
      endcase
    end
  end

  always_comb begin
    res = 32'd0;
    case (opt)
      4'd7:    res = hi;
      4'd8:    res = lo;
      default: res = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus randomized ops
// compared against a plain-arithmetic HI/LO model.
module tb_mdu;

  logic        clk, rst_n, start, cancel, busy;
  logic [31:0] v1, v2, res, hi, lo;
  logic [3:0]  opt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .v1(v1), .v2(v2), .opt(opt), .start(start),
    .cancel(cancel), .busy(busy), .res(res), .hi(hi), .lo(lo)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int exp_cycles(input int op);
    return (op == 1 || op == 2) ? 5 : 10;
  endfunction

  // Reference: what HI/LO must hold once the op has completed.
  function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    case (op)
      1: begin q = sa * sb; m_hi = q[63:32]; m_lo = q[31:0]; end
      2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      4: if (b != 0) begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
      5: m_hi = a;
      6: m_lo = a;
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles, output bit stable);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; stable = 1;
    opt = 4'(op); v1 = a; v2 = b; start = 1;
    @(negedge clk);
    start = 0; opt = 0;
    cycles = 0;
    while (busy && cycles < 30) begin
      cycles++;
      if (hi !== h0 || lo !== l0) stable = 0;
      @(negedge clk);
    end
    model(op, a, b);
  endtask

  task automatic set_mt(input int op, input logic [31:0] a);
    opt = 4'(op); v1 = a; start = 1;
    @(negedge clk);
    start = 0; opt = 0;
    model(op, a, 0);
  endtask

  task automatic test_reset;
    rst_n = 0; start = 0; cancel = 0; opt = 0; v1 = 0; v2 = 0;
    #12;
    n_checks++;
    if (busy !== 0 || hi !== 0 || lo !== 0 || res !== 0) begin
      n_fail++;
      $display("FAIL reset_values busy=%b hi=%h lo=%h res=%h required all 0", busy, hi, lo, res);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic check_op(input string name, input int op, input logic [31:0] a,
                          input logic [31:0] b);
    int c; bit s;
    do_op(op, a, b, c, s);
    n_checks++;
    if (c !== exp_cycles(op) || !s) begin
      n_fail++;
      $display("FAIL %s_busy cycles=%0d stable=%0b required cycles=%0d stable=1", name, c, s, exp_cycles(op));
    end
    n_checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL %s_result hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_mult;
    check_op("mult", 1, 32'hFFFFFFFE, 32'd3);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      n_fail++; $display("FAIL mult_const hi=%h lo=%h required FFFFFFFF FFFFFFFA", hi, lo);
    end
    check_op("multu", 2, 32'hFFFFFFFE, 32'd3);
    n_checks++;
    if (hi !== 32'h2 || lo !== 32'hFFFFFFFA) begin
      n_fail++; $display("FAIL multu_const hi=%h lo=%h required 00000002 FFFFFFFA", hi, lo);
    end
  endtask

  task automatic test_div;
    check_op("div", 3, 32'hFFFFFFF9, 32'd2);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL div_const hi=%h lo=%h required FFFFFFFF FFFFFFFD", hi, lo);
    end
    check_op("divu", 4, 32'd7, 32'd2);
    n_checks++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      n_fail++; $display("FAIL divu_const hi=%h lo=%h required 1 3", hi, lo);
    end
    check_op("div_ovf", 3, 32'h80000000, 32'hFFFFFFFF);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'h80000000) begin
      n_fail++; $display("FAIL div_ovf_const hi=%h lo=%h required 0 80000000", hi, lo);
    end
  endtask

  task automatic test_mt_divzero;
    set_mt(5, 32'h1234);
    opt = 4'd7; #1;
    n_checks++;
    if (res !== 32'h1234) begin
      n_fail++; $display("FAIL mthi_read res=%h required 00001234", res);
    end
    opt = 0;
    set_mt(6, 32'h5678);
    check_op("divu_zero", 4, 32'h9999, 32'd0);
    check_op("div_zero", 3, 32'hDEAD, 32'd0);
    n_checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      n_fail++; $display("FAIL divzero_keep hi=%h lo=%h required 1234 5678", hi, lo);
    end
    opt = 4'd7; #1;
    n_checks++;
    if (res !== 32'h1234) begin n_fail++; $display("FAIL mfhi res=%h required 00001234", res); end
    opt = 4'd8; #1;
    n_checks++;
    if (res !== 32'h5678) begin n_fail++; $display("FAIL mflo res=%h required 00005678", res); end
    opt = 4'd9; #1;
    n_checks++;
    if (res !== 32'h0) begin n_fail++; $display("FAIL res_other res=%h required 0", res); end
    opt = 0;
    @(negedge clk);
  endtask

  task automatic test_cancel;
    int c;
    opt = 1; v1 = 32'd100; v2 = 32'd200; start = 1; cancel = 1;
    @(negedge clk);
    start = 0; cancel = 0; opt = 0;
    n_checks++;
    if (busy !== 0 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL cancel_start busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    end
    opt = 1; v1 = 32'hFFFF0001; v2 = 32'h00012345; start = 1;
    @(negedge clk);
    start = 0; opt = 0; c = 0;
    while (busy && c < 30) begin
      c++;
      cancel = (c == 2);
      @(negedge clk);
    end
    cancel = 0;
    model(1, 32'hFFFF0001, 32'h00012345);
    n_checks++;
    if (c !== 5 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL cancel_mid cycles=%0d hi=%h lo=%h required 5 %h %h", c, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_start_while_busy;
    int c, extra;
    opt = 1; v1 = 32'd11; v2 = 32'd13; start = 1;
    @(negedge clk);
    start = 0; opt = 0; c = 0;
    while (busy && c < 30) begin
      c++;
      if (c == 3) begin opt = 1; v1 = 32'd1000; v2 = 32'd1000; start = 1; end
      else begin start = 0; opt = 0; end
      @(negedge clk);
    end
    start = 0; opt = 0;
    model(1, 32'd11, 32'd13);
    extra = 0;
    repeat (4) begin if (busy) extra++; @(negedge clk); end
    n_checks++;
    if (c !== 5 || extra !== 0 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL start_busy cycles=%0d extra=%0d hi=%h lo=%h required 5 0 %h %h", c, extra, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back;
    check_op("b2b_a", 2, 32'h0000FFFF, 32'h00010001);
    check_op("b2b_b", 4, 32'hFFFFFFFF, 32'd10);
    check_op("b2b_c", 1, 32'h7FFFFFFF, 32'h80000000);
  endtask

  task automatic test_reset_mid;
    int c, late;
    opt = 3; v1 = 32'd1000; v2 = 32'd7; start = 1;
    @(negedge clk);
    start = 0; opt = 0; c = 1;
    while (c < 3) begin c++; @(negedge clk); end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (busy !== 0 || hi !== 0 || lo !== 0) begin
      n_fail++; $display("FAIL reset_mid busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
    end
    m_hi = 0; m_lo = 0;
    @(negedge clk); rst_n = 1;
    late = 0;
    repeat (12) begin if (busy || hi !== 0 || lo !== 0) late++; @(negedge clk); end
    n_checks++;
    if (late !== 0) begin
      n_fail++; $display("FAIL reset_release bad_cycles=%0d required 0", late);
    end
  endtask

  task automatic test_random;
    int op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(1, 6);
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = {28'd0, 4'($urandom)};
      if (op >= 5) begin
        set_mt(op, a);
        n_checks++;
        if (hi !== m_hi || lo !== m_lo) begin
          n_fail++; $display("FAIL rand_mt op=%0d hi=%h lo=%h required %h %h", op, hi, lo, m_hi, m_lo);
        end
      end else begin
        check_op("rand", op, a, b);
      end
      opt = 4'($urandom_range(7, 8)); #1;
      n_checks++;
      if (res !== ((opt == 7) ? m_hi : m_lo)) begin
        n_fail++; $display("FAIL rand_mf opt=%0d res=%h required %h", opt, res, (opt == 7) ? m_hi : m_lo);
      end
      opt = 0;
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mt_divzero;
    test_cancel;
    test_start_while_busy;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
